vend_credit_ctrl: RTL and testbench
===================================

// Module: vend_credit_ctrl
// PURPOSE
//  Parametrised, clocked vending controller that replaces the fixed combinational next-state table.
//  - Accumulates credit from two coin inputs (shilling, crown) with programmable values.
//  - Vends when credit >= PRICE, then pays change one unit per cycle.
//  - Supports cancel/refund, coin rejection and credit saturation.
//  - Sits between the coin-acceptor decoder and the dispenser/change-hopper drivers.
// PARAMETERS
//  CREDIT_W    5   width of the credit register (units)
//  SHILLING_V  1   credit units added by coin[0]
//  CROWN_V     5   credit units added by coin[1]
//  PRICE       6   credit units consumed by one vend
//  MAX_CREDIT  20  highest credit the block accepts; must be < 2**CREDIT_W
// PORTS
//  clk          in   1         rising-edge clock
//  reset        in   1         synchronous, active-high reset
//  coin         in   2         [0]=shilling, [1]=crown; 2'b11 = both in the same cycle
//  cancel       in   1         refund request
//  credit       out  CREDIT_W  current credit (registered)
//  dispense     out  1         1-cycle product-release pulse
//  change_pulse out  1         1 unit of change per asserted cycle
//  coin_reject  out  1         coin(s) in this cycle not credited; return to customer
//  busy         out  1         high in VEND or CHANGE
// BEHAVIOUR
//  Reset
//  - Synchronous: next edge forces state=IDLE and credit=0.
//  - dispense, change_pulse, coin_reject and busy are all 0 while reset is high.
//  - Reset mid-VEND/CHANGE discards the remaining credit; no further pulses.
//  States: IDLE (credit==0), COLLECT, VEND, CHANGE
//  - Coin value: add = (coin[0]?SHILLING_V:0) + (coin[1]?CROWN_V:0), computed at CREDIT_W+1 bits.
//  - In IDLE/COLLECT with coin!=0 and cancel=0:
//    - sum = credit + add.
//    - If sum > MAX_CREDIT: coin_reject=1 that cycle (combinational); credit unchanged.
//    - Otherwise credit <= sum, then:
//      - sum >= PRICE -> VEND
//      - else -> COLLECT
//  - VEND (dispense=1 for exactly this cycle)
//    - credit <= credit - PRICE.
//    - Next state is CHANGE if the result is > 0, otherwise IDLE.
//  - CHANGE (change_pulse=1 each cycle)
//    - credit <= credit - 1; when it reaches 0, go to IDLE.
//    - change_pulse is high for exactly N consecutive cycles for N units owed.
//  - cancel
//    - In COLLECT: go to CHANGE and refund all credit; no dispense.
//    - In IDLE, VEND or CHANGE: ignored.
//  - Simultaneous events
//    - cancel with coin!=0 in COLLECT: cancel wins, coin_reject=1.
//    - coin!=0 in VEND/CHANGE: coin_reject=1, credit unaffected.
//  - Latency
//    - A coin sampled at edge N is visible on credit after edge N.
//    - dispense is high in the cycle after that edge.
//    - The first change_pulse follows one cycle after dispense.
//  - dispense, change_pulse and busy decode from the registered state.
//  - coin_reject is the only Mealy output.
//  Elaboration checks (fatal)
//  - PRICE > 0.
//  - SHILLING_V > 0 and CROWN_V > 0.
//  - PRICE <= MAX_CREDIT < 2**CREDIT_W.
// STRUCTURE
//  - vend_pkg holds:
//    - typedef enum logic [1:0] vend_state_t {IDLE, COLLECT, VEND, CHANGE}
//    - localparams COIN_SHILLING=0, COIN_CROWN=1
//  - Sub-module vend_coin_adder (combinational): coin + credit -> sum and overflow flag.
//  - Top level: state register, credit register, output decode.
// TESTING (default parameters unless stated)
//  1. Crown, then shilling -> credit 5, then 6; dispense 1 cycle; credit 0; IDLE; zero change_pulse.
//  2. coin=2'b11 for one cycle -> credit 6; dispense next cycle; no change; busy high 1 cycle.
//  3. Crown, crown -> credit 10; dispense; credit 4; exactly 4 consecutive change_pulse; then IDLE, busy=0.
//  4. Three shillings, then cancel -> 3 change_pulse cycles, dispense never asserted, credit 0.
//  5. Coin during CHANGE, and coin with cancel in COLLECT -> coin_reject=1 that cycle; credit unaffected.
//     PRICE=MAX_CREDIT=20, credit 18 + crown -> coin_reject=1, credit stays 18.
//  6. reset high during CHANGE with credit 3 -> next cycle credit 0, IDLE, change_pulse=0 afterwards.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and coin bit positions for the vending credit controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } vend_state_t;

    localparam int COIN_SHILLING = 0;
    localparam int COIN_CROWN    = 1;

endpackage

// File: rtl/vend_coin_adder.sv
// Combinational coin valuation: credit plus this cycle's coins, with an
// over-limit flag so the caller can bounce coins that would exceed MAX_CREDIT.
module vend_coin_adder
    import vend_pkg::*;
#(
    parameter int CREDIT_W   = 5,
    parameter int SHILLING_V = 1,
    parameter int CROWN_V    = 5,
    parameter int MAX_CREDIT = 20
) (
    input  logic [1:0]          coin,
    input  logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W:0]   sum,
    output logic                over
);

    localparam logic [CREDIT_W:0] SHIL_ADD  = (CREDIT_W+1)'(SHILLING_V);
    localparam logic [CREDIT_W:0] CROWN_ADD = (CREDIT_W+1)'(CROWN_V);
    localparam logic [CREDIT_W:0] MAX_SUM   = (CREDIT_W+1)'(MAX_CREDIT);

    logic [CREDIT_W:0] add;

    // One extra bit keeps the overflow test exact before truncation.
    function automatic logic exceeds_max(input logic [CREDIT_W:0] v);
        return v > MAX_SUM;
    endfunction

    always_comb begin
        add = '0;
        if (coin[COIN_SHILLING]) add = SHIL_ADD;
        if (coin[COIN_CROWN])    add = add + CROWN_ADD;
        sum  = {1'b0, credit} + add;
        over = exceeds_max(sum);
    end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending credit controller: accumulates coins, vends at PRICE, then pays
// change one unit per cycle; supports cancel/refund and coin rejection.
module vend_credit_ctrl
    import vend_pkg::*;
#(
    parameter int CREDIT_W   = 5,
    parameter int SHILLING_V = 1,
    parameter int CROWN_V    = 5,
    parameter int PRICE      = 6,
    parameter int MAX_CREDIT = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                busy
);

    if (PRICE <= 0) begin : g_chk_price
        $fatal(1, "vend_credit_ctrl: PRICE must be > 0");
    end
    if (SHILLING_V <= 0 || CROWN_V <= 0) begin : g_chk_coin
        $fatal(1, "vend_credit_ctrl: coin values must be > 0");
    end
    if (PRICE > MAX_CREDIT || MAX_CREDIT >= (1 << CREDIT_W)) begin : g_chk_max
        $fatal(1, "vend_credit_ctrl: need PRICE <= MAX_CREDIT < 2**CREDIT_W");
    end

    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   PRICE_SUM = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] ONE_C     = CREDIT_W'(1);

    vend_state_t         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W:0]   sum;
    logic                over;
    logic                coin_any;
    logic                reject;

    vend_coin_adder #(
        .CREDIT_W   (CREDIT_W),
        .SHILLING_V (SHILLING_V),
        .CROWN_V    (CROWN_V),
        .MAX_CREDIT (MAX_CREDIT)
    ) u_adder (
        .coin   (coin),
        .credit (credit_q),
        .sum    (sum),
        .over   (over)
    );

    assign coin_any = |coin;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject   = 1'b0;
        case (state_q)
            IDLE, COLLECT: begin
                // Cancel only matters once credit exists; it then beats any coin.
                if (state_q == COLLECT && cancel) begin
                    state_d = CHANGE;
                    reject  = coin_any;
                end else if (coin_any) begin
                    if (over) begin
                        reject = 1'b1;
                    end else begin
                        credit_d = sum[CREDIT_W-1:0];
                        state_d  = (sum >= PRICE_SUM) ? VEND : COLLECT;
                    end
                end
            end
            VEND: begin
                credit_d = credit_q - PRICE_C;
                state_d  = (credit_q > PRICE_C) ? CHANGE : IDLE;
                reject   = coin_any;
            end
            CHANGE: begin
                reject = coin_any;
                if (credit_q <= ONE_C) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end else begin
                    credit_d = credit_q - ONE_C;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    // Moore outputs from the registered state, forced quiet during reset.
    assign credit       = credit_q;
    assign dispense     = !reset && (state_q == VEND);
    assign change_pulse = !reset && (state_q == CHANGE);
    assign busy         = !reset && (state_q == VEND || state_q == CHANGE);
    assign coin_reject  = !reset && reject;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Directed bench for vend_credit_ctrl: default instance plus a PRICE=MAX_CREDIT=20 instance.
module tb_vend_credit_ctrl;

    logic       clk;
    logic       reset;
    logic [1:0] coin, coin2;
    logic       cancel, cancel2;
    logic [4:0] credit, credit2;
    logic       dispense, change_pulse, coin_reject, busy;
    logic       dispense2, change_pulse2, coin_reject2, busy2;

    int nvec = 0;
    int nerr = 0;

    vend_credit_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .coin         (coin),
        .cancel       (cancel),
        .credit       (credit),
        .dispense     (dispense),
        .change_pulse (change_pulse),
        .coin_reject  (coin_reject),
        .busy         (busy)
    );

    vend_credit_ctrl #(.PRICE(20), .MAX_CREDIT(20)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .coin         (coin2),
        .cancel       (cancel2),
        .credit       (credit2),
        .dispense     (dispense2),
        .change_pulse (change_pulse2),
        .coin_reject  (coin_reject2),
        .busy         (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; coin = 2'b10; cancel = 1'b0; coin2 = 2'b00; cancel2 = 1'b0;
        tick(); tick();
        chk("rst_credit", 32'(credit), 0);
        chk("rst_dispense", 32'(dispense), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_change", 32'(change_pulse), 0);
        chk("rst_reject", 32'(coin_reject), 0);
        reset = 1'b0; coin = 2'b00;
        tick();
        chk("idle_credit", 32'(credit), 0);

        // 1: crown then shilling, exact price
        coin = 2'b10; tick();
        chk("t1_credit5", 32'(credit), 5);
        chk("t1_nodisp", 32'(dispense), 0);
        coin = 2'b01; tick();
        chk("t1_credit6", 32'(credit), 6);
        chk("t1_dispense", 32'(dispense), 1);
        chk("t1_busy", 32'(busy), 1);
        coin = 2'b00; tick();
        chk("t1_credit0", 32'(credit), 0);
        chk("t1_disp_off", 32'(dispense), 0);
        chk("t1_nochange", 32'(change_pulse), 0);
        chk("t1_idle", 32'(busy), 0);

        // 2: both coins in one cycle
        coin = 2'b11; tick();
        chk("t2_credit6", 32'(credit), 6);
        chk("t2_dispense", 32'(dispense), 1);
        coin = 2'b00; tick();
        chk("t2_credit0", 32'(credit), 0);
        chk("t2_busy_off", 32'(busy), 0);
        chk("t2_nochange", 32'(change_pulse), 0);

        // 3: two crowns, 4 units of change
        coin = 2'b10; tick();
        chk("t3_credit5", 32'(credit), 5);
        tick();
        chk("t3_credit10", 32'(credit), 10);
        chk("t3_dispense", 32'(dispense), 1);
        coin = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_change", 32'(change_pulse), 1);
            chk("t3_credit", 32'(credit), 32'(4 - i));
            chk("t3_nodisp", 32'(dispense), 0);
        end
        tick();
        chk("t3_change_end", 32'(change_pulse), 0);
        chk("t3_busy_end", 32'(busy), 0);
        chk("t3_credit_end", 32'(credit), 0);

        // 4: three shillings then cancel
        coin = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_accum", 32'(credit), 32'(i + 1));
        end
        coin = 2'b00; cancel = 1'b1; tick();
        cancel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_refund", 32'(change_pulse), 1);
            chk("t4_credit", 32'(credit), 32'(3 - i));
            chk("t4_nodisp", 32'(dispense), 0);
            tick();
        end
        chk("t4_change_end", 32'(change_pulse), 0);
        chk("t4_credit_end", 32'(credit), 0);
        chk("t4_busy_end", 32'(busy), 0);

        // cancel in IDLE is ignored
        cancel = 1'b1; tick();
        cancel = 1'b0;
        chk("idle_cancel_busy", 32'(busy), 0);
        chk("idle_cancel_credit", 32'(credit), 0);

        // 5a: coin during CHANGE is rejected, credit keeps counting down
        coin = 2'b10; tick(); tick();
        coin = 2'b00; tick();
        chk("t5a_in_change", 32'(credit), 4);
        coin = 2'b10; #1;
        chk("t5a_reject", 32'(coin_reject), 1);
        tick();
        coin = 2'b00; #1;
        chk("t5a_credit", 32'(credit), 3);
        chk("t5a_reject_off", 32'(coin_reject), 0);
        tick(); tick(); tick();
        chk("t5a_drained", 32'(credit), 0);
        chk("t5a_idle", 32'(busy), 0);

        // 5b: coin during VEND is rejected
        coin = 2'b11; tick();
        coin = 2'b01; #1;
        chk("t5b_vend_reject", 32'(coin_reject), 1);
        tick();
        coin = 2'b00;
        chk("t5b_credit", 32'(credit), 0);
        chk("t5b_nochange", 32'(change_pulse), 0);

        // 5c: coin with cancel in COLLECT -> cancel wins
        coin = 2'b01; tick();
        chk("t5c_credit1", 32'(credit), 1);
        coin = 2'b10; cancel = 1'b1; #1;
        chk("t5c_reject", 32'(coin_reject), 1);
        tick();
        coin = 2'b00; cancel = 1'b0;
        chk("t5c_credit", 32'(credit), 1);
        chk("t5c_refund", 32'(change_pulse), 1);
        tick();
        chk("t5c_credit0", 32'(credit), 0);
        chk("t5c_idle", 32'(busy), 0);

        // 5d: PRICE=MAX_CREDIT=20 overflow rejection
        coin2 = 2'b10; tick(); tick(); tick();
        coin2 = 2'b01; tick(); tick(); tick();
        chk("t5d_credit18", 32'(credit2), 18);
        coin2 = 2'b10; #1;
        chk("t5d_reject", 32'(coin_reject2), 1);
        tick();
        chk("t5d_credit_kept", 32'(credit2), 18);
        coin2 = 2'b01; tick(); tick();
        coin2 = 2'b00;
        chk("t5d_credit20", 32'(credit2), 20);
        chk("t5d_dispense", 32'(dispense2), 1);
        tick();
        chk("t5d_credit0", 32'(credit2), 0);
        chk("t5d_nochange", 32'(change_pulse2), 0);

        // 6: reset during CHANGE with credit 3
        coin = 2'b10; tick(); tick();
        coin = 2'b00; tick(); tick();
        chk("t6_credit3", 32'(credit), 3);
        chk("t6_in_change", 32'(change_pulse), 1);
        reset = 1'b1; #1;
        chk("t6_rst_quiet", 32'(change_pulse), 0);
        tick();
        chk("t6_credit0", 32'(credit), 0);
        reset = 1'b0; tick();
        chk("t6_after_change", 32'(change_pulse), 0);
        chk("t6_after_busy", 32'(busy), 0);
        chk("t6_after_credit", 32'(credit), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
